perf_word_fifo: RTL

//   Elastic buffer between the cache-event counter (32-bit snapshot word + 1-cycle write pulse)
//   and the word-to-byte separator that feeds the UART transmitter. Absorbs counter bursts

---
 rtl/perf_fifo_pkg.sv | 28 ++
 rtl/perf_fifo_mem.sv | 39 +++
 rtl/perf_word_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/perf_fifo_pkg.sv
// ----------------------------------------------------------------------------
// perf_fifo_pkg
//   Shared types and default sizes for the performance-counter word FIFO.
//   The default widths/depth are also used by the event counter and the
//   word-to-byte separator so that the whole capture path agrees.
//   Contents:
//     state_t        output-pacing FSM state (IDLE, PULSE, GAP)
//     DEF_DATA_W     default stored word width
//     DEF_DEPTH      default FIFO depth
//     DEF_GAP_CYC    default idle cycles after each output pulse
//     DEF_OVF_W      default dropped-word counter width
//     GAP_CNT_W      width of the gap counter (covers 1..15)
// ----------------------------------------------------------------------------
package perf_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_GAP_CYC = 2;
    localparam int DEF_OVF_W   = 16;
    localparam int GAP_CNT_W   = 4;

endpackage : perf_fifo_pkg

// File: rtl/perf_fifo_mem.sv
// ----------------------------------------------------------------------------
// perf_fifo_mem
//   DEPTH x DATA_W storage array for the word FIFO. Synchronous write,
//   asynchronous read. The array itself is not reset; validity of entries is
//   tracked entirely by the pointers and level counter in the parent.
//   Ports:
//     clk       in   system clock
//     we_i      in   write enable
//     waddr_i   in   write address (ADDR_W)
//     wdata_i   in   write data (DATA_W)
//     raddr_i   in   read address (ADDR_W)
//     rdata_o   out  read data, combinational from raddr_i (DATA_W)
// ----------------------------------------------------------------------------
module perf_fifo_mem
    import perf_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : perf_fifo_mem

// File: rtl/perf_word_fifo.sv
// ----------------------------------------------------------------------------
// perf_word_fifo
//   Elastic buffer between the cache-event counter and the word-to-byte
//   separator feeding the UART. Stores counter snapshots, re-issues each one
//   as a single-cycle valid pulse when the separator is ready, and enforces an
//   idle gap after each pulse so a slow-to-drop ready cannot cause a double
//   pop. Writes arriving while full are dropped and counted.
//   Ports:
//     clk             in   system clock
//     rstn            in   async active-low reset, clears all state
//     wr_data_i       in   word from event counter (DATA_W)
//     wr_en_i         in   1-cycle write strobe
//     ready_i         in   separator idle, may accept a new word
//     clr_ovf_i       in   synchronous clear of overflow_cnt_o
//     data_o          out  word being presented, held until next pop
//     valid_o         out  1-cycle pulse qualifying data_o
//     full_o          out  level == DEPTH
//     empty_o         out  level == 0
//     level_o         out  stored entries, 0..DEPTH (ADDR_W+1)
//     overflow_cnt_o  out  saturating count of dropped writes (OVF_W)
// ----------------------------------------------------------------------------
module perf_word_fifo
    import perf_fifo_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int OVF_W   = DEF_OVF_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_en_i,
    input  logic              ready_i,
    input  logic              clr_ovf_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic [OVF_W-1:0]  overflow_cnt_o
);

    localparam logic [ADDR_W:0]        LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [GAP_CNT_W-1:0]   GAP_LOAD = GAP_CNT_W'(GAP_CYC - 1);
    localparam logic [OVF_W-1:0]       OVF_ONE  = OVF_W'(1);

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      level_q, level_d;
    logic                 full_q, empty_q;
    logic [OVF_W-1:0]     ovf_q, ovf_d;
    state_t               state_q;
    logic [GAP_CNT_W-1:0] gap_q;
    logic [DATA_W-1:0]    data_q;
    logic                 valid_q;
    logic [DATA_W-1:0]    rd_data;

    logic pop_now;
    logic push;
    logic drop;

    // empty_q is registered, so a word pushed this cycle cannot be popped
    // until the next one; at full a concurrent pop frees the slot.
    assign pop_now = (state_q == IDLE) && ready_i && !empty_q;
    assign push    = wr_en_i && (!full_q || pop_now);
    assign drop    = wr_en_i && full_q && !pop_now;

    perf_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        wr_ptr_d = push    ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_now ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        unique case ({push, pop_now})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A clear coinciding with a drop keeps that drop in the count.
        ovf_d = ovf_q;
        if (clr_ovf_i) begin
            ovf_d = drop ? OVF_ONE : '0;
        end else if (drop) begin
            ovf_d = sat_inc(ovf_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == LVL_FULL);
            empty_q  <= (level_d == '0);
            ovf_q    <= ovf_d;
        end
    end

    // Output pacing: IDLE pops, PULSE presents the word for one cycle, GAP
    // ignores ready_i for GAP_CYC cycles before the next pop is allowed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop_now) begin
                        data_q  <= rd_data;
                        valid_q <= 1'b1;
                        state_q <= PULSE;
                    end
                end
                PULSE: begin
                    gap_q   <= GAP_LOAD;
                    state_q <= GAP;
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_o         = data_q;
    assign valid_o        = valid_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign level_o        = level_q;
    assign overflow_cnt_o = ovf_q;

endmodule : perf_word_fifo
